iconn_bus_arbiter: RTL and testbench
====================================

ICONN_BUS_ARBITER -- requirements
Module: iconn_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2: number of requesters sharing the interconnect bus (legal 2..8).
REQ-002 SHALL have parameter DATA_W, default 2: width of the shared interconnect bus.
REQ-003 SHALL have parameter HOLD_MAX, default 16: maximum grant length in cycles (legal >= 2).
REQ-004 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_i  input  NUM_REQ  per-requester bus request, level.
REQ-007 SHALL have port done_i  input  NUM_REQ  per-requester release; only the owner's bit is used.
REQ-008 SHALL have port wdata_i  input  NUM_REQ*DATA_W  per-requester drive data; requester k occupies bits [k*DATA_W +: DATA_W].
REQ-009 SHALL have port gnt_o  output  NUM_REQ  one-hot grant, registered.
REQ-010 SHALL have port owner_o  output  clog2(NUM_REQ)  index of the current owner; 0 when no grant.
REQ-011 SHALL have port bus_en_o  output  1  bus drive enable; equals OR of gnt_o.
REQ-012 SHALL have port bus_data_o  output  DATA_W  wdata_i slice of the owner while bus_en_o=1, else all zeros.
REQ-013 SHALL have port timeout_o  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-014 SHALL implement FSM states IDLE, GRANT, TURNAROUND.
REQ-015 IDLE: if any req_i bit is 1, SHALL select a winner round-robin starting at pointer rr_ptr, set gnt_o and owner_o, and enter GRANT on the next edge (req-to-grant latency 1 cycle).
REQ-016 On each grant, rr_ptr SHALL become (winner+1) mod NUM_REQ.
REQ-017 GRANT: gnt_o SHALL stay constant; bus_data_o SHALL follow wdata_i of the owner combinationally.
REQ-018 GRANT: hold counter SHALL be 0 in the first GRANT cycle and increment by 1 each GRANT cycle.
REQ-019 GRANT exits to TURNAROUND on done_i[owner]=1 or req_i[owner]=0; gnt_o SHALL clear on that edge.
REQ-020 TURNAROUND SHALL last exactly 1 cycle with gnt_o=0 and bus_en_o=0 (no two drivers on the net in adjacent cycles), then go to IDLE.
REQ-021 Minimum owner-to-owner handover SHALL therefore be 2 idle cycles on bus_en_o.
REQ-022 IDLE with no request SHALL hold all outputs at zero; rr_ptr SHALL be retained.
REQ-023 done_i or req_i bits of non-owners SHALL have no effect during GRANT and TURNAROUND.
REQ-024 A requester that drops req_i in IDLE before being granted SHALL NOT be granted.

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE, gnt_o=0, owner_o=0, bus_en_o=0, bus_data_o=0, timeout_o=0, hold counter=0, rr_ptr=0, including mid-grant.
REQ-026 After rst_n deasserts, the first grant SHALL be evaluated on the first rising edge with rst_n=1.

Configuration
REQ-027 Macro ICONN_ARB_TIMEOUT_EN SHALL compile the hold-limit feature in or out.
REQ-028 With ICONN_ARB_TIMEOUT_EN defined: when the hold counter equals HOLD_MAX-1 and the owner has neither released nor dropped req, the FSM SHALL go to TURNAROUND and pulse timeout_o for exactly 1 cycle (the TURNAROUND cycle).
REQ-029 With ICONN_ARB_TIMEOUT_EN defined: if done_i[owner] and the limit occur in the same cycle, the release SHALL win and timeout_o SHALL stay 0.
REQ-030 Without ICONN_ARB_TIMEOUT_EN: a grant SHALL be held indefinitely until release; timeout_o SHALL be tied 0; the hold counter SHALL be absent.

Verification
REQ-031 NUM_REQ=2: req_i=2'b01 at cycle 0 -> gnt_o=01 at cycle 1; done_i[0] at cycle 4 -> gnt_o=00 at cycle 5; TURNAROUND cycle 5; IDLE cycle 6.
REQ-032 req_i=2'b11 held, each owner releases after 3 cycles -> grants alternate 01,10,01,... with bus_en_o=0 for exactly 2 cycles between grants.
REQ-033 Owner 1 grants, wdata_i[1 slice]=2'b10, wdata_i[0 slice]=2'b01 -> bus_data_o=2'b10; after release -> bus_data_o=2'b00.
REQ-034 TIMEOUT_EN, HOLD_MAX=4, req_i=2'b01 never released -> gnt_o=01 for exactly 4 cycles, then timeout_o=1 for one cycle, then regrant after IDLE.
REQ-035 TIMEOUT_EN, HOLD_MAX=4, done_i[0] in the 4th GRANT cycle -> timeout_o stays 0.
REQ-036 rst_n pulled low for 1 cycle mid-GRANT -> all outputs 0 asynchronously; with req_i=2'b10 held, after release gnt_o=10 on the first edge with rst_n=1.

Source files
------------

// File: rtl/iconn_bus_arbiter.sv
// Round-robin owner arbiter for a shared interconnect bus with a 1-cycle turnaround gap.
// Latency: req to grant 1 cycle; no backpressure, an owner holds until done/drop (or hold limit
// when ICONN_ARB_TIMEOUT_EN is defined).
module iconn_bus_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int DATA_W   = 2,
    parameter int HOLD_MAX = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ-1:0]          done_i,
    input  logic [NUM_REQ*DATA_W-1:0]   wdata_i,
    output logic [NUM_REQ-1:0]          gnt_o,
    output logic [$clog2(NUM_REQ)-1:0]  owner_o,
    output logic                        bus_en_o,
    output logic [DATA_W-1:0]           bus_data_o,
    output logic                        timeout_o
);

    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GRANT = 2'd1,
        S_TURN = 2'd2
    } state_t;

    state_t             r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [PW-1:0]      r_owner;
    logic [PW-1:0]      r_rr_ptr;

    logic               w_any_req;
    logic               w_found;
    logic [PW:0]        w_sum;
    logic [PW-1:0]      w_win;
    logic [PW-1:0]      w_next_ptr;
    logic               w_release;

`ifdef ICONN_ARB_TIMEOUT_EN
    localparam int HW = $clog2(HOLD_MAX);
    logic [HW-1:0]      r_hold;
    logic               r_timeout;
`else
    logic               w_unused_hold;
    assign w_unused_hold = ^HOLD_MAX;
`endif

    // Scan requesters starting at the round-robin pointer, wrapping modulo NUM_REQ.
    always_comb begin
        w_any_req = |req_i;
        w_found   = 1'b0;
        w_win     = r_rr_ptr;
        w_sum     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, r_rr_ptr} + (PW+1)'(i);
            if (w_sum >= (PW+1)'(NUM_REQ)) begin
                w_sum = w_sum - (PW+1)'(NUM_REQ);
            end
            if (!w_found && req_i[w_sum[PW-1:0]]) begin
                w_win   = w_sum[PW-1:0];
                w_found = 1'b1;
            end
        end
    end

    assign w_next_ptr = (w_win == PW'(NUM_REQ - 1)) ? '0 : w_win + PW'(1);
    assign w_release  = done_i[r_owner] | ~req_i[r_owner];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_owner  <= '0;
            r_rr_ptr <= '0;
`ifdef ICONN_ARB_TIMEOUT_EN
            r_hold    <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
`ifdef ICONN_ARB_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_gnt    <= NUM_REQ'(1) << w_win;
                        r_owner  <= w_win;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= S_GRANT;
`ifdef ICONN_ARB_TIMEOUT_EN
                        r_hold   <= '0;
`endif
                    end
                end
                S_GRANT: begin
                    if (w_release) begin
                        r_gnt   <= '0;
                        r_owner <= '0;
                        r_state <= S_TURN;
`ifdef ICONN_ARB_TIMEOUT_EN
                        r_hold  <= '0;
                    end else if (r_hold == HW'(HOLD_MAX - 1)) begin
                        // Release has priority over the limit, so timeout only fires here.
                        r_gnt     <= '0;
                        r_owner   <= '0;
                        r_state   <= S_TURN;
                        r_hold    <= '0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_hold <= r_hold + HW'(1);
`endif
                    end
                end
                S_TURN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= '0;
                    r_owner <= '0;
                end
            endcase
        end
    end

    assign gnt_o      = r_gnt;
    assign owner_o    = r_owner;
    assign bus_en_o   = |r_gnt;
    assign bus_data_o = bus_en_o ? wdata_i[r_owner*DATA_W +: DATA_W] : '0;

`ifdef ICONN_ARB_TIMEOUT_EN
    assign timeout_o = r_timeout;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_iconn_bus_arbiter.sv
// Scoreboard bench for iconn_bus_arbiter (NUM_REQ=2, DATA_W=2, HOLD_MAX=4).
// Honours ICONN_ARB_TIMEOUT_EN in its reference model.
module tb_iconn_bus_arbiter;

    localparam int NUM_REQ  = 2;
    localparam int DATA_W   = 2;
    localparam int HOLD_MAX = 4;
    localparam int PW       = 1;
`ifdef ICONN_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic [NUM_REQ-1:0]         req_i = '0;
    logic [NUM_REQ-1:0]         done_i = '0;
    logic [NUM_REQ*DATA_W-1:0]  wdata_i = '0;
    logic [NUM_REQ-1:0]         gnt_o;
    logic [PW-1:0]              owner_o;
    logic                       bus_en_o;
    logic [DATA_W-1:0]          bus_data_o;
    logic                       timeout_o;

    iconn_bus_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .HOLD_MAX(HOLD_MAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_i),
        .done_i    (done_i),
        .wdata_i   (wdata_i),
        .gnt_o     (gnt_o),
        .owner_o   (owner_o),
        .bus_en_o  (bus_en_o),
        .bus_data_o(bus_data_o),
        .timeout_o (timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NUM_REQ-1:0] gnt;
        logic [PW-1:0]      owner;
        logic               en;
        logic [DATA_W-1:0]  data;
        logic               to;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: 0 idle, 1 grant, 2 turnaround.
    int   m_state, m_owner, m_ptr, m_cnt;
    bit   m_to;

    // Handover-gap and timeout observation.
    bit   gap_chk = 1'b0;
    bit   seen_grant = 1'b0;
    int   gap = 0;
    int   to_seen = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_state = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_to = 1'b0;
    endfunction

    function automatic void m_update(input logic [1:0] req, input logic [1:0] done);
        m_to = 1'b0;
        case (m_state)
            0: if (req != 2'b00) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    int k;
                    k = (m_ptr + i) % NUM_REQ;
                    if (req[k] && m_state == 0) begin
                        m_owner = k;
                        m_state = 1;
                    end
                end
                m_ptr = (m_owner + 1) % NUM_REQ;
                m_cnt = 0;
            end
            1: if (done[m_owner] || !req[m_owner]) begin
                m_state = 2;
            end else if (TO_EN && m_cnt == HOLD_MAX - 1) begin
                m_state = 2;
                m_to    = 1'b1;
            end else begin
                m_cnt++;
            end
            default: m_state = 0;
        endcase
    endfunction

    function automatic exp_t m_expect(input logic [3:0] wd);
        exp_t e;
        e = '0;
        if (m_state == 1) begin
            e.gnt[m_owner] = 1'b1;
            e.owner        = PW'(m_owner);
            e.en           = 1'b1;
            e.data         = wd[m_owner*DATA_W +: DATA_W];
        end
        e.to = m_to;
        return e;
    endfunction

    // rel_n > 0: owner asserts done in its rel_n-th grant cycle.
    task automatic step(input logic [1:0] req, input logic [1:0] done, input int rel_n,
                        input logic [3:0] wd);
        logic [1:0] d;
        @(posedge clk);
        if (!rst_n) m_reset();
        else        m_update(req_i, done_i);
        #1;
        d = done;
        if (rel_n > 0 && m_state == 1 && m_cnt == rel_n - 1) d[m_owner] = 1'b1;
        req_i   = req;
        done_i  = d;
        wdata_i = wd;
        sb_q.push_back(m_expect(wd));
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check_val("gnt",      32'(gnt_o),      32'(mon_e.gnt));
            check_val("owner",    32'(owner_o),    32'(mon_e.owner));
            check_val("bus_en",   32'(bus_en_o),   32'(mon_e.en));
            check_val("bus_data", 32'(bus_data_o), 32'(mon_e.data));
            check_val("timeout",  32'(timeout_o),  32'(mon_e.to));
        end
        if (timeout_o) to_seen++;
        if (bus_en_o) begin
            if (gap_chk && seen_grant && gap > 0) check_val("handover_gap", 32'(gap), 32'd2);
            seen_grant = 1'b1;
            gap = 0;
        end else begin
            gap++;
        end
    end

    initial begin
        m_reset();
        #2;
        check_val("rst_gnt",     32'(gnt_o),      32'd0);
        check_val("rst_owner",   32'(owner_o),    32'd0);
        check_val("rst_bus_en",  32'(bus_en_o),   32'd0);
        check_val("rst_data",    32'(bus_data_o), 32'd0);
        check_val("rst_timeout", 32'(timeout_o),  32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single requester: grant at cycle 1, release at cycle 4, turnaround 5, idle 6.
        for (int i = 0; i < 8; i++) begin
            step(2'b01, 2'b00, 4, 4'($urandom));
            @(negedge clk);
            #1;
            if (i == 1) check_val("c1_gnt", 32'(gnt_o), 32'b01);
            if (i == 4) check_val("c4_gnt", 32'(gnt_o), 32'b01);
            if (i == 5) check_val("c5_gnt", 32'(gnt_o), 32'b00);
            if (i == 6) check_val("c6_bus_en", 32'(bus_en_o), 32'd0);
        end
        for (int i = 0; i < 4; i++) step(2'b00, 2'b00, 0, 4'($urandom));

        // Both requesting, 3-cycle tenures: alternation with a 2-cycle gap.
        seen_grant = 1'b0;
        gap_chk    = 1'b1;
        for (int i = 0; i < 24; i++) step(2'b11, 2'b00, 3, 4'($urandom));
        gap_chk = 1'b0;
        for (int i = 0; i < 4; i++) step(2'b00, 2'b00, 0, 4'($urandom));

        // Owner 1 drives 2'b10 while requester 0 offers 2'b01.
        for (int i = 0; i < 6; i++) begin
            step(2'b10, 2'b00, 3, 4'b1001);
            @(negedge clk);
            #1;
            if (i == 2) check_val("own1_data", 32'(bus_data_o), 32'b10);
            if (i == 4) check_val("rel_data",  32'(bus_data_o), 32'b00);
        end
        for (int i = 0; i < 4; i++) step(2'b00, 2'b00, 0, 4'($urandom));

        // Random requests, releases and non-owner noise.
        for (int i = 0; i < 60; i++) step(2'($urandom), 2'($urandom), 0, 4'($urandom));
        for (int i = 0; i < 4; i++) step(2'b00, 2'b00, 0, 4'($urandom));

        // Never released: held forever, or cut by the hold limit when enabled.
        to_seen = 0;
        for (int i = 0; i < 14; i++) step(2'b01, 2'b00, 0, 4'($urandom));
        check_val("timeout_seen", 32'(to_seen != 0), 32'(TO_EN));
        for (int i = 0; i < 4; i++) step(2'b00, 2'b00, 0, 4'($urandom));

        // Release in the 4th grant cycle coincides with the limit; release wins.
        to_seen = 0;
        for (int i = 0; i < 8; i++) step(2'b01, 2'b00, 4, 4'($urandom));
        check_val("release_wins", 32'(to_seen), 32'd0);
        for (int i = 0; i < 4; i++) step(2'b00, 2'b00, 0, 4'($urandom));

        // Asynchronous reset mid-grant, then regrant on the first edge out of reset.
        for (int i = 0; i < 3; i++) step(2'b10, 2'b00, 0, 4'($urandom));
        @(negedge clk);
        #1 check_val("pre_rst_gnt", 32'(gnt_o), 32'b10);
        @(posedge clk);
        #1 rst_n = 1'b0;
        m_reset();
        sb_q.delete();
        sb_q.push_back(m_expect(wdata_i));
        #1;
        check_val("arst_gnt",    32'(gnt_o),      32'd0);
        check_val("arst_owner",  32'(owner_o),    32'd0);
        check_val("arst_bus_en", 32'(bus_en_o),   32'd0);
        check_val("arst_data",   32'(bus_data_o), 32'd0);
        step(2'b10, 2'b00, 0, 4'($urandom));
        rst_n = 1'b1;
        step(2'b10, 2'b00, 0, 4'($urandom));
        @(negedge clk);
        #1 check_val("post_rst_gnt", 32'(gnt_o), 32'b10);
        for (int i = 0; i < 3; i++) step(2'b10, 2'b00, 2, 4'($urandom));

        @(negedge clk);
        #1 check_val("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
